// File: rtl/fb_write_arbiter.sv
// Round-robin arbiter for the shared fb0/fb1 write port with one hold register per requester.
// Latency: accept at edge k, write strobe registered at edge k+1; ready deasserts only while a full hold loses arbitration.
module fb_write_arbiter #(
  parameter int ADDR_WIDTH   = 13,
  parameter int DATA_WIDTH   = 8,
  parameter int PANEL_WIDTH  = 104,
  parameter int PANEL_HEIGHT = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  a_valid,
  output logic                  a_ready,
  input  logic [7:0]            a_x,
  input  logic [4:0]            a_y,
  input  logic                  a_panel,
  input  logic [DATA_WIDTH-1:0] a_data,
  input  logic                  b_valid,
  output logic                  b_ready,
  input  logic [7:0]            b_x,
  input  logic [4:0]            b_y,
  input  logic                  b_panel,
  input  logic [DATA_WIDTH-1:0] b_data,
  output logic                  wr_enable0,
  output logic                  wr_enable1,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [DATA_WIDTH-1:0] wr_data,
  output logic                  grant_b,
  output logic                  oob_err
);

  typedef struct packed {
    logic [7:0]            x;
    logic [4:0]            y;
    logic                  panel;
    logic [DATA_WIDTH-1:0] data;
  } pix_t;

  localparam int CW = (ADDR_WIDTH > 16) ? ADDR_WIDTH : 16;
  localparam logic [7:0] PW8 = 8'(PANEL_WIDTH);

  logic a_full, b_full, last_b;
  pix_t a_hold, b_hold, sel;
  logic gnt_a, gnt_b, any_gnt, oob;
  logic [4:0] yr;
  logic [CW-1:0] addr_calc;

  // On a tie, the requester that did not win last time is served.
  assign gnt_a   = a_full && (!b_full || last_b);
  assign gnt_b   = b_full && (!a_full || !last_b);
  assign any_gnt = gnt_a || gnt_b;
  assign a_ready = !a_full || gnt_a;
  assign b_ready = !b_full || gnt_b;

  assign sel = gnt_b ? b_hold : a_hold;
  assign oob = sel.x >= PW8;
  // Top and bottom half rows are swapped in scan order; with 32 rows that is bit 4.
  assign yr  = sel.y ^ 5'b10000;

  always_comb begin
    addr_calc = CW'(sel.x[2:0]) * CW'(4 * PANEL_WIDTH)
              + CW'(sel.x[7:3]) * CW'(PANEL_HEIGHT)
              + CW'(yr);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      a_full     <= 1'b0;
      b_full     <= 1'b0;
      last_b     <= 1'b1;
      a_hold     <= '0;
      b_hold     <= '0;
      wr_enable0 <= 1'b0;
      wr_enable1 <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
      grant_b    <= 1'b0;
      oob_err    <= 1'b0;
    end else begin
      if (a_valid && a_ready) begin
        a_full <= 1'b1;
        a_hold <= '{x: a_x, y: a_y, panel: a_panel, data: a_data};
      end else if (gnt_a) begin
        a_full <= 1'b0;
      end

      if (b_valid && b_ready) begin
        b_full <= 1'b1;
        b_hold <= '{x: b_x, y: b_y, panel: b_panel, data: b_data};
      end else if (gnt_b) begin
        b_full <= 1'b0;
      end

      wr_enable0 <= 1'b0;
      wr_enable1 <= 1'b0;
      oob_err    <= 1'b0;
      if (any_gnt) begin
        last_b <= gnt_b;
        // Off-panel pixels are consumed without touching the write port.
        if (oob) begin
          oob_err <= 1'b1;
        end else begin
          wr_enable0 <= !sel.panel;
          wr_enable1 <= sel.panel;
          wr_addr    <= addr_calc[ADDR_WIDTH-1:0];
          wr_data    <= sel.data;
          grant_b    <= gnt_b;
        end
      end
    end
  end

endmodule
